// File: rtl/exe_div_seq_if.sv
// ----------------------------------------------------------------------------
// exe_div_seq_if
//   Handshake/operand bundle between the EXE stage (master) and the
//   multi-cycle divide sequencer (slave).
//
//   Handshake: EXE raises start_i with operands stable and keeps it high
//   until it samples ready_o=1. Operands are captured only on the accept
//   cycle (IDLE & start_i & ~annul_i). ready_o marks quot_o/rem_o valid.
//   Dropping start_i in DONE retires the result. annul_i cancels any
//   pending or in-flight operation.
//
//   Signals:
//     start_i      EXE -> div  request
//     annul_i      EXE -> div  flush / branch kill
//     signed_i     EXE -> div  1 = DIV/REM, 0 = DIVU/REMU
//     dividend_i   EXE -> div  op1
//     divisor_i    EXE -> div  op2
//     quot_o       div -> EXE  quotient (valid while ready_o)
//     rem_o        div -> EXE  remainder (valid while ready_o)
//     ready_o      div -> EXE  result valid
//     stall_req_o  div -> ctrl freeze IF..EXE
// ----------------------------------------------------------------------------
interface exe_div_seq_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            annul_i;
    logic            signed_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [XLEN-1:0] quot_o;
    logic [XLEN-1:0] rem_o;
    logic            ready_o;
    logic            stall_req_o;

    modport master (
        output start_i, annul_i, signed_i, dividend_i, divisor_i,
        input  quot_o, rem_o, ready_o, stall_req_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, dividend_i, divisor_i,
        output quot_o, rem_o, ready_o, stall_req_o
    );
endinterface

// File: rtl/exe_div_seq.sv
// ----------------------------------------------------------------------------
// exe_div_seq
//   Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU). One restoring
//   iteration per cycle on operand magnitudes, sign fix-up on the way into
//   DONE. Divide-by-zero and signed overflow short-circuit to DONE in one
//   cycle.
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        synchronous reset, active-high
//     bus          exe_div_seq_if.slave (start/annul/signed/operands in,
//                  quot/rem/ready/stall_req out)
//     dbg_state_o  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ----------------------------------------------------------------------------
module exe_div_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    exe_div_seq_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_dvd;   // dividend magnitude, shifts out MSB-first, collects quotient bits
    logic [XLEN-1:0] r_dsr;   // divisor magnitude
    logic [XLEN-1:0] r_prem;  // partial remainder
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic            r_ready;

    logic            w_accept;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic [XLEN:0]   w_prem_sh;
    logic [XLEN+1:0] w_trial;
    logic            w_qbit;
    logic [XLEN-1:0] w_prem_nx;
    logic [XLEN-1:0] w_dvd_nx;
    logic            w_last;

    assign w_accept   = (r_state == S_IDLE) & bus.start_i & ~bus.annul_i;
    assign w_div_zero = (bus.divisor_i == '0);
    assign w_ovf      = bus.signed_i
                      & (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      & (bus.divisor_i == '1);

    assign w_a_neg = bus.signed_i & bus.dividend_i[XLEN-1];
    assign w_b_neg = bus.signed_i & bus.divisor_i[XLEN-1];
    // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
    assign w_a_abs = w_a_neg ? -bus.dividend_i : bus.dividend_i;
    assign w_b_abs = w_b_neg ? -bus.divisor_i  : bus.divisor_i;

    // Two guard bits on the trial subtract so its MSB is a clean sign.
    assign w_prem_sh = {r_prem, r_dvd[XLEN-1]};
    assign w_trial   = {1'b0, w_prem_sh} - {2'b00, r_dsr};
    assign w_qbit    = ~w_trial[XLEN+1];
    assign w_prem_nx = w_qbit ? w_trial[XLEN-1:0] : w_prem_sh[XLEN-1:0];
    assign w_dvd_nx  = {r_dvd[XLEN-2:0], w_qbit};
    assign w_last    = (r_cnt == CW'(XLEN - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_prem  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div_zero) begin
                            r_quot  <= '1;
                            r_rem   <= bus.dividend_i;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_ovf) begin
                            r_quot  <= bus.dividend_i;
                            r_rem   <= '0;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dvd   <= w_a_abs;
                            r_dsr   <= w_b_abs;
                            r_prem  <= '0;
                            r_cnt   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // Annul beats the final iteration: no result is published.
                    if (bus.annul_i) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_prem <= w_prem_nx;
                        r_dvd  <= w_dvd_nx;
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quot  <= r_neg_q ? -w_dvd_nx  : w_dvd_nx;
                            r_rem   <= r_neg_r ? -w_prem_nx : w_prem_nx;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Holding start_i keeps the result; it never relaunches.
                    if (bus.annul_i || !bus.start_i) begin
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_quot  <= '0;
                    r_rem   <= '0;
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quot_o      = r_quot;
    assign bus.rem_o       = r_rem;
    assign bus.ready_o     = r_ready;
    assign bus.stall_req_o = w_accept | (r_state == S_BUSY);
    assign dbg_state_o     = r_state;
endmodule

// File: tb/tb_exe_div_seq.sv
module tb_exe_div_seq;
  localparam int XLEN = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  exe_div_seq_if #(.XLEN(XLEN)) bus ();

  exe_div_seq #(.XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  logic [XLEN-1:0] exp_quot_q[$];
  logic [XLEN-1:0] exp_rem_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference model built from native signed/unsigned division
  task automatic model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn,
                       output logic [XLEN-1:0] q, output logic [XLEN-1:0] r, output int lat);
    int sa;
    int sb;
    sa = a;
    sb = b;
    lat = 1;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      lat = XLEN + 1;
      if (sgn) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  // driver tasks
  task automatic launch(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b0;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    #1;
    chk("stall_cycle0", {31'b0, bus.stall_req_o}, 32'd1);
  endtask

  task automatic wait_ready(input int exp_lat, input string name);
    int c;
    int lat;
    logic [XLEN-1:0] eq;
    logic [XLEN-1:0] er;
    c = 0;
    lat = 0;
    while (lat == 0 && c < 40) begin
      @(negedge clk);
      #1;
      c++;
      if (bus.ready_o === 1'b1) lat = c;
      else chk({name, "_stall_busy"}, {31'b0, bus.stall_req_o}, 32'd1);
    end
    eq = exp_quot_q.pop_front();
    er = exp_rem_q.pop_front();
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready_o not seen within 40 cycles, expected at %0d", name, exp_lat);
    end else begin
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_stall_done"}, {31'b0, bus.stall_req_o}, 32'd0);
      chk({name, "_state_done"}, {30'b0, dbg_state}, {30'b0, ST_DONE});
      chk({name, "_quot"}, bus.quot_o, eq);
      chk({name, "_rem"}, bus.rem_o, er);
    end
  endtask

  task automatic release_start(input string name);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    chk({name, "_rel_ready"}, {31'b0, bus.ready_o}, 32'd0);
    chk({name, "_rel_quot"}, bus.quot_o, 32'd0);
    chk({name, "_rel_rem"}, bus.rem_o, 32'd0);
    chk({name, "_rel_state"}, {30'b0, dbg_state}, {30'b0, ST_IDLE});
  endtask

  task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn,
                       input string name);
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    int lat;
    model(a, b, sgn, q, r, lat);
    exp_quot_q.push_back(q);
    exp_rem_q.push_back(r);
    launch(a, b, sgn);
    wait_ready(lat, name);
    release_start(name);
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_quot", bus.quot_o, 32'd0);
    chk("reset_rem", bus.rem_o, 32'd0);
    chk("reset_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("reset_stall", {31'b0, bus.stall_req_o}, 32'd0);
    chk("reset_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    do_op(32'd100, 32'd7, 1'b0, "udiv_100_7");
    chk("udiv_100_7_const_q", 32'd100 / 32'd7, 32'd14);
  endtask

  task automatic test_signed;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, "sdiv_m7_m2");
  endtask

  task automatic test_special;
    do_op(32'd5, 32'd0, 1'b1, "sdiv_by_zero");
    do_op(32'd5, 32'd0, 1'b0, "udiv_by_zero");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "udiv_big");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "udiv_max_1");
  endtask

  task automatic test_annul;
    int seen;
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(negedge clk);
    #1;
    chk("annul_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk("annul_stall", {31'b0, bus.stall_req_o}, 32'd0);
    chk("annul_ready", {31'b0, bus.ready_o}, 32'd0);
    bus.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) seen++;
    end
    chk("annul_no_ready", seen, 32'd0);
    do_op(32'h64, 32'hA, 1'b0, "after_annul");

    // annul on the final iteration wins
    launch(32'd1000, 32'd3, 1'b0);
    repeat (32) @(negedge clk);
    chk("annul_last_busy", {30'b0, dbg_state}, {30'b0, ST_BUSY});
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(negedge clk);
    #1;
    chk("annul_last_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    chk("annul_last_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("annul_last_quot", bus.quot_o, 32'd0);
    bus.annul_i = 1'b0;

    // annul in IDLE blocks the accept
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    #1;
    chk("annul_idle_stall", {31'b0, bus.stall_req_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("annul_idle_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    launch(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    chk("rstmid_busy", {30'b0, dbg_state}, {30'b0, ST_BUSY});
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_quot", bus.quot_o, 32'd0);
    chk("rstmid_rem", bus.rem_o, 32'd0);
    chk("rstmid_ready", {31'b0, bus.ready_o}, 32'd0);
    chk("rstmid_stall", {31'b0, bus.stall_req_o}, 32'd0);
    chk("rstmid_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    rst = 1'b0;
  endtask

  task automatic test_hold_done;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    int lat;
    model(32'd1000, 32'd3, 1'b0, q, r, lat);
    exp_quot_q.push_back(q);
    exp_rem_q.push_back(r);
    launch(32'd1000, 32'd3, 1'b0);
    wait_ready(lat, "hold");
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("hold_ready", {31'b0, bus.ready_o}, 32'd1);
      chk("hold_quot", bus.quot_o, 32'd333);
      chk("hold_rem", bus.rem_o, 32'd1);
      chk("hold_state", {30'b0, dbg_state}, {30'b0, ST_DONE});
      chk("hold_stall", {31'b0, bus.stall_req_o}, 32'd0);
    end
    release_start("hold");
  endtask

  task automatic test_back_to_back;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic sgn;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if (i == 5) b = b | 32'h8000_0000;
      sgn = 1'($urandom_range(0, 1));
      do_op(a, b, sgn, "random");
    end
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_annul();
    test_reset_mid();
    test_hold_done();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
